fifo_rd_pack: RTL and testbench

FIFO_RD_PACK -- requirements
Module: fifo_rd_pack

---
 rtl/fifo_pkg.sv | 14 +
 rtl/pack_outreg.sv | 33 +++
 rtl/fifo_rd_pack.sv | 124 ++++++++++++
 tb/tb_fifo_rd_pack.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FSM encoding and lane-counter sizing for the read-side packer
package fifo_pkg;

  typedef enum logic {
    PACK = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Bits needed to count lanes 0..ratio-1; never narrower than one bit.
  function automatic int cnt_width(input int ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/pack_outreg.sv
// rtl/pack_outreg.sv - one-beat output register with valid/ready hold
module pack_outreg #(
  parameter int DSIZE = 8,
  parameter int RATIO = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [RATIO*DSIZE-1:0] load_data,
  input  logic [RATIO-1:0]       load_keep,
  input  logic                   ready,
  output logic [RATIO*DSIZE-1:0] data,
  output logic [RATIO-1:0]       keep,
  output logic                   valid
);

  // Load a new beat when offered (the packer only offers when the slot is free or draining);
  // otherwise keep the beat frozen until it is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      keep  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      keep  <= load_keep;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_pack.sv
// rtl/fifo_rd_pack.sv - packs RATIO show-ahead FIFO words into one wide beat with flush
module fifo_rd_pack
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int RATIO = 4
) (
  input  logic                   rclk,
  input  logic                   rrst,
  input  logic [DSIZE-1:0]       rdata,
  input  logic                   rempty,
  output logic                   rinc,
  input  logic                   flush,
  output logic [RATIO*DSIZE-1:0] m_data,
  output logic [RATIO-1:0]       m_keep,
  output logic                   m_valid,
  input  logic                   m_ready
);

  localparam int            CW        = cnt_width(RATIO);
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  state_t                       state;
  state_t                       state_next;
  logic [CW-1:0]                cnt;
  logic [RATIO-1:0][DSIZE-1:0]  pack_q;
  logic                         flush_pend;

  logic                         blocked;
  logic                         out_free;
  logic                         stall;
  logic                         pop;
  logic                         last_pop;
  logic                         flush_req;
  logic                         flush_xfer;
  logic                         xfer;
  logic [CW:0]                  lanes_written;
  logic [RATIO-1:0][DSIZE-1:0]  beat_data;
  logic [RATIO-1:0]             beat_keep;

  // Pop/transfer decisions and the beat that would be handed to the output register this cycle.
  always_comb begin
    blocked       = m_valid && !m_ready;
    out_free      = !blocked;
    // Stop popping only when the next pop (or a pending flush) would need the busy output slot.
    stall         = blocked && ((cnt == LAST_LANE) || (state == HOLD));
    pop           = !rrst && !rempty && !stall;
    last_pop      = pop && (cnt == LAST_LANE);
    // A flush counts a word popped in the same cycle, so it never produces an empty beat.
    flush_req     = (flush || flush_pend) && ((cnt != '0) || pop);
    flush_xfer    = flush_req && out_free && !last_pop;
    xfer          = last_pop || flush_xfer;
    lanes_written = {1'b0, cnt} + {{CW{1'b0}}, pop};
    beat_data     = pack_q;
    if (pop) begin
      beat_data[cnt] = rdata;
    end
    // Shifting by RATIO empties the shifted mask, which yields all-ones keep for a full beat.
    beat_keep     = ~({RATIO{1'b1}} << lanes_written);
  end

  assign rinc = pop;

  // Next state: HOLD while a wanted transfer is blocked by an unaccepted beat.
  always_comb begin
    state_next = state;
    case (state)
      PACK: begin
        if (blocked && (flush_req || ((cnt == LAST_LANE) && !rempty))) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (m_ready) begin
          state_next = PACK;
        end
      end
      default: state_next = PACK;
    endcase
  end

  // State register.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state <= PACK;
    end else begin
      state <= state_next;
    end
  end

  // Packing lanes, lane counter and the remembered flush request.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      cnt        <= '0;
      pack_q     <= '0;
      flush_pend <= 1'b0;
    end else begin
      flush_pend <= flush_req && !xfer;
      if (xfer) begin
        cnt    <= '0;
        pack_q <= '0;
      end else if (pop) begin
        cnt         <= cnt + CW'(1);
        pack_q[cnt] <= rdata;
      end
    end
  end

  pack_outreg #(
    .DSIZE (DSIZE),
    .RATIO (RATIO)
  ) u_outreg (
    .clk       (rclk),
    .rst       (rrst),
    .load      (xfer),
    .load_data (beat_data),
    .load_keep (beat_keep),
    .ready     (m_ready),
    .data      (m_data),
    .keep      (m_keep),
    .valid     (m_valid)
  );

endmodule

// File: tb/tb_fifo_rd_pack.sv
// tb/tb_fifo_rd_pack.sv - scoreboard bench for the FIFO read-side packer
module tb_fifo_rd_pack;

  localparam int DSIZE = 8;
  localparam int RATIO = 4;

  logic        rclk = 1'b0;
  logic        rrst;
  logic [7:0]  rdata;
  logic        rempty;
  logic        rinc;
  logic        flush;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_ready;

  logic [7:0]  fq[$];
  logic [31:0] exp_data[$];
  logic [3:0]  exp_keep[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          pop_total = 0;
  logic        model_popped;

  fifo_rd_pack #(
    .DSIZE (DSIZE),
    .RATIO (RATIO)
  ) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .rdata   (rdata),
    .rempty  (rempty),
    .rinc    (rinc),
    .flush   (flush),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  always #5 rclk = ~rclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic void fifo_refresh();
    rempty = (fq.size() == 0);
    rdata  = (fq.size() != 0) ? fq[0] : 8'h00;
  endfunction

  task automatic step();
    @(posedge rclk);
    #2;
  endtask

  task automatic push_word(input logic [7:0] w);
    fq.push_back(w);
    fifo_refresh();
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [3:0] k);
    exp_data.push_back(d);
    exp_keep.push_back(k);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_data.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(name, exp_data.size(), 0);
  endtask

  task automatic wait_fifo_empty(input string name);
    for (int i = 0; i < 10 && fq.size() != 0; i++) step();
    check(name, fq.size(), 0);
  endtask

  // Show-ahead FIFO model: consume the head word on every edge where rinc was high.
  always @(posedge rclk) begin
    model_popped = rinc;
    #1;
    if (model_popped && fq.size() > 0) begin
      void'(fq.pop_front());
      pop_total++;
    end
    fifo_refresh();
  end

  // Monitor: every accepted beat must match the oldest expected beat.
  always @(negedge rclk) begin
    if (!rrst && m_valid && m_ready) begin
      if (exp_data.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL beat_unexpected: got data 0x%0h keep 0x%0h, required no beat", m_data, m_keep);
      end else begin
        check("beat_data", m_data, exp_data.pop_front());
        check("beat_keep", {28'b0, m_keep}, {28'b0, exp_keep.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          run;
    int          best;
    int          base;
    int          changes;
    logic        seen;
    logic [31:0] held;

    rrst    = 1'b1;
    m_ready = 1'b0;
    flush   = 1'b0;
    fifo_refresh();
    push_word(8'h5A);
    repeat (2) @(negedge rclk);
    check("reset_m_valid", m_valid, 0);
    check("reset_m_data", m_data, 0);
    check("reset_m_keep", m_keep, 0);
    check("reset_rinc", rinc, 0);
    fq.delete();
    fifo_refresh();
    step();
    rrst = 1'b0;

    // S1 steady stream
    m_ready = 1'b1;
    base = pop_total;
    expect_beat(32'h04030201, 4'hF);
    expect_beat(32'h08070605, 4'hF);
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    run  = 0;
    best = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge rclk);
      if (rinc) begin
        run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
    end
    check("s1_rinc_run", best, 8);
    check("s1_pops", pop_total - base, 8);
    drain("s1_drain", 20);

    // S2 backpressure
    m_ready = 1'b0;
    base = pop_total;
    expect_beat(32'h24232221, 4'hF);
    expect_beat(32'h28272625, 4'hF);
    expect_beat(32'h2C2B2A29, 4'hF);
    for (int i = 0; i < 12; i++) push_word(8'h21 + 8'(i));
    seen    = 1'b0;
    changes = 0;
    held    = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge rclk);
      if (m_valid) begin
        if (!seen) begin
          seen = 1'b1;
          held = m_data;
        end else if (m_data !== held) begin
          changes++;
        end
      end
    end
    check("s2_pops_before_stall", pop_total - base, 7);
    check("s2_rinc_low", rinc, 0);
    check("s2_held_valid", m_valid, 1);
    check("s2_held_data", m_data, 32'h24232221);
    check("s2_held_stable", changes, 0);
    step();
    m_ready = 1'b1;
    drain("s2_drain", 30);
    check("s2_total_pops", pop_total - base, 12);

    // S3 flush of a partial beat
    expect_beat(32'h0000BBAA, 4'h3);
    push_word(8'hAA);
    push_word(8'hBB);
    wait_fifo_empty("s3_fifo_popped");
    flush = 1'b1;
    step();
    flush = 1'b0;
    drain("s3_drain", 10);

    // S4 flush with nothing packed
    flush = 1'b1;
    repeat (3) step();
    flush = 1'b0;
    changes = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge rclk);
      if (m_valid) changes++;
    end
    check("s4_no_empty_beat", changes, 0);

    // S5 flush coinciding with the third pop
    expect_beat(32'h00332211, 4'h7);
    step();
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    drain("s5_drain", 10);

    // S6 reset mid-operation
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'h41 + 8'(i));
    wait_fifo_empty("s6_first_beat_popped");
    push_word(8'h51);
    push_word(8'h52);
    wait_fifo_empty("s6_partial_popped");
    check("s6_beat_pending", m_valid, 1);
    rrst = 1'b1;
    #1;
    check("s6_valid_async", m_valid, 0);
    check("s6_data_async", m_data, 0);
    check("s6_keep_async", m_keep, 0);
    check("s6_rinc_async", rinc, 0);
    fq.delete();
    fifo_refresh();
    step();
    step();
    rrst = 1'b0;
    base = pop_total;
    step();
    check("s6_no_pop_after_release", pop_total - base, 0);
    m_ready = 1'b1;
    expect_beat(32'h64636261, 4'hF);
    for (int i = 0; i < 4; i++) push_word(8'h61 + 8'(i));
    drain("s6_drain", 20);
    repeat (4) step();

    check("final_scoreboard_empty", exp_data.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
